// File: rtl/ift_sram_pipelined.sv
// Taint-tracked single-port data SRAM with bitwise taint shadow, pipelined reads,
// a taint-scrub FSM and a sticky poison flag for tainted control/address inputs.
module ift_sram_pipelined #(
    parameter int unsigned Width         = 32,
    parameter int unsigned Depth         = 32768,
    parameter int unsigned ReadLatency   = 1,
    parameter int unsigned AddrTaintMode = 1,
    localparam int unsigned Aw           = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic             we_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic             rvalid_o,
    output logic [Width-1:0] rdata_o,
    input  logic             req_i_t0,
    input  logic             we_i_t0,
    input  logic [Aw-1:0]    addr_i_t0,
    input  logic [Width-1:0] wdata_i_t0,
    input  logic [Width-1:0] wmask_i_t0,
    output logic [Width-1:0] rdata_o_t0,
    input  logic             taint_clear_i,
    output logic             busy_o,
    output logic             poison_o
);

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_depth_chk
        $error("ift_sram_pipelined: Depth must be a power of two >= 2");
    end
    if (ReadLatency < 1 || ReadLatency > 4) begin : g_lat_chk
        $error("ift_sram_pipelined: ReadLatency must be within 1..4");
    end

    typedef enum logic {
        SCRUB,
        READY
    } state_e;

    state_e          state;
    logic [Aw-1:0]   scrub_cnt;

    logic [Width-1:0] mem       [Depth];
    logic [Width-1:0] taint_mem [Depth];

    logic             accept;
    logic             wr_en;
    logic             rd_en;
    logic             ctrl_tainted;
    logic             poison_set;
    logic [Width-1:0] rd_data;
    logic [Width-1:0] rd_taint;

    assign accept       = req_i & gnt_o;
    assign wr_en        = accept & we_i;
    assign rd_en        = accept & ~we_i;
    assign ctrl_tainted = req_i_t0 | we_i_t0 | (|addr_i_t0);
    assign poison_set   = (AddrTaintMode != 0) &&
                          ((accept && ctrl_tainted) || (!gnt_o && req_i && req_i_t0));

    // gnt_o/busy_o are registered and follow the state only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= SCRUB;
            scrub_cnt <= '0;
            gnt_o     <= 1'b0;
            busy_o    <= 1'b1;
            poison_o  <= 1'b0;
        end else begin
            case (state)
                SCRUB: begin
                    if (taint_clear_i) begin
                        scrub_cnt <= '0;
                    end else if (scrub_cnt == Aw'(Depth - 1)) begin
                        state    <= READY;
                        gnt_o    <= 1'b1;
                        busy_o   <= 1'b0;
                        poison_o <= 1'b0;
                    end else begin
                        scrub_cnt <= scrub_cnt + Aw'(1);
                    end
                end
                READY: begin
                    if (taint_clear_i) begin
                        state     <= SCRUB;
                        scrub_cnt <= '0;
                        gnt_o     <= 1'b0;
                        busy_o    <= 1'b1;
                    end
                end
                default: state <= SCRUB;
            endcase
            // A fresh poison event wins over the end-of-scrub clear.
            if (poison_set) begin
                poison_o <= 1'b1;
            end
        end
    end

    // Writes are only accepted in READY, so they never collide with scrub writes.
    always_ff @(posedge clk_i) begin
        if (state == SCRUB) begin
            taint_mem[scrub_cnt] <= '0;
        end
        if (wr_en) begin
            mem[addr_i]       <= (mem[addr_i] & ~wmask_i) | (wdata_i & wmask_i);
            taint_mem[addr_i] <= (wmask_i & (wdata_i_t0 | wmask_i_t0)) |
                                 (~wmask_i & (taint_mem[addr_i] | wmask_i_t0));
        end
    end

    assign rd_data  = mem[addr_i];
    assign rd_taint = taint_mem[addr_i] | {Width{poison_o}} |
                      {Width{(AddrTaintMode != 0) && (|addr_i_t0)}};

    logic [ReadLatency:1] pipe_v;
    logic [Width-1:0]     pipe_d [1:ReadLatency];
    logic [Width-1:0]     pipe_t [1:ReadLatency];

    // Data stages only load on a valid entry, so the last stage holds its value between reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_v <= '0;
            for (int unsigned k = 1; k <= ReadLatency; k++) begin
                pipe_d[k] <= '0;
                pipe_t[k] <= '0;
            end
        end else begin
            pipe_v[1] <= rd_en;
            if (rd_en) begin
                pipe_d[1] <= rd_data;
                pipe_t[1] <= rd_taint;
            end
            for (int unsigned k = 2; k <= ReadLatency; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                if (pipe_v[k-1]) begin
                    pipe_d[k] <= pipe_d[k-1];
                    pipe_t[k] <= pipe_t[k-1];
                end
            end
        end
    end

    assign rvalid_o   = pipe_v[ReadLatency];
    assign rdata_o    = pipe_d[ReadLatency];
    assign rdata_o_t0 = pipe_t[ReadLatency];

endmodule
